ahb_arbiter: RTL

Round-robin AHB bus arbiter that shares one AHB slave port among up to 16 masters. It drives `HGRANT`, `HMASTER` and `HMASTLOCK` toward the masters and slave. It holds ownership through fixed-length bursts and locked sequences. Masters that receive a SPLIT response are masked from arbitration until the slave releases them via `HSPLIT`.

---
 rtl/ahb_arbiter_if.sv | 26 ++
 rtl/ahb_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// Arbitration-side AHB signal bundle shared by the masters, the slave and the arbiter.
// The requester modport drives requests and slave responses; the arbiter modport drives grants.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [1:0]             HRESP;
    logic [15:0]            HSPLIT;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [3:0]             HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP, HSPLIT,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter for up to 16 masters: holds ownership through fixed bursts
// and locked sequences, and masks SPLIT masters until the slave releases them.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    localparam logic [3:0]             DEF_IDX    = 4'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    logic [3:0]             r_grant_idx;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [3:0]             r_hmaster;
    logic                   r_hmastlock;
    logic [3:0]             r_dmaster;
    logic [3:0]             r_burst_rem;
    logic [NUM_MASTERS-1:0] r_split_mask;
    logic [3:0]             r_rr_ptr;

    logic [3:0]             w_burst_next;
    logic                   w_owner_lock;
    arb_state_e             w_state;
    logic                   w_arb_ok;
    logic [NUM_MASTERS-1:0] w_eligible;
    logic [NUM_MASTERS-1:0] w_split_set;
    logic [NUM_MASTERS-1:0] w_split_next;
    logic [NUM_MASTERS-1:0] w_next_hgrant;
    logic [3:0]             w_winner;
    logic                   w_found;
    int                     w_dist;
    int                     w_best;
    logic                   w_unused_hsplit;

    // Release strobes for masters that do not exist carry no meaning here.
    assign w_unused_hsplit = ^bus.HSPLIT;

    // Beats still to issue after this edge; a SPLIT/RETRY first cycle abandons the burst.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_burst_next = r_burst_rem;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                TRANS_IDLE:   w_burst_next = 4'd0;
                TRANS_BUSY:   w_burst_next = r_burst_rem;
                TRANS_NONSEQ: begin
                    case (bus.HBURST)
                        3'd2, 3'd3: w_burst_next = 4'd3;
                        3'd4, 3'd5: w_burst_next = 4'd7;
                        3'd6, 3'd7: w_burst_next = 4'd15;
                        default:    w_burst_next = 4'd0;
                    endcase
                end
                TRANS_SEQ:    w_burst_next = (r_burst_rem != 4'd0) ? r_burst_rem - 4'd1 : 4'd0;
                default:      w_burst_next = r_burst_rem;
            endcase
        end else if (bus.HRESP == RESP_SPLIT || bus.HRESP == RESP_RETRY) begin
            w_burst_next = 4'd0;
        end
    end

    always_comb begin
        w_owner_lock = 1'b0;
        w_split_set  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant_idx == 4'(i)) w_owner_lock = bus.HLOCK[i];
            if (!bus.HREADY && bus.HRESP == RESP_SPLIT && r_dmaster == 4'(i)) w_split_set[i] = 1'b1;
        end
        // A new SPLIT outranks a simultaneous release of the same master.
        w_split_next = (r_split_mask & ~bus.HSPLIT[NUM_MASTERS-1:0]) | w_split_set;
    end

    always_comb begin
        if (w_owner_lock)               w_state = ST_LOCKED;
        else if (w_burst_next >= 4'd2)  w_state = ST_BURST;
        else                            w_state = ST_ARB;
    end

    assign w_arb_ok   = bus.HREADY && (w_state == ST_ARB);
    assign w_eligible = bus.HBUSREQ & ~r_split_mask;

    // Pick the eligible master closest after rr_ptr; the pointer itself is searched last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = DEF_IDX;
        w_best   = NUM_MASTERS;
        w_dist   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_eligible[i]) begin
                w_dist = (i > int'(r_rr_ptr)) ? i - int'(r_rr_ptr) - 1
                                              : i + NUM_MASTERS - int'(r_rr_ptr) - 1;
                if (w_dist < w_best) begin
                    w_best   = w_dist;
                    w_winner = 4'(i);
                    w_found  = 1'b1;
                end
            end
        end
        w_next_hgrant = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_next_hgrant[i] = (w_winner == 4'(i));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant_idx  <= DEF_IDX;
            r_hgrant     <= DEF_ONEHOT;
            r_hmaster    <= DEF_IDX;
            r_hmastlock  <= 1'b0;
            r_dmaster    <= DEF_IDX;
            r_burst_rem  <= 4'd0;
            r_split_mask <= '0;
            r_rr_ptr     <= DEF_IDX;
        end else begin
            // NOTE: non-blocking updates so the HMASTER -> dmaster pipeline reads pre-edge values.
            r_burst_rem  <= w_burst_next;
            r_split_mask <= w_split_next;
            if (w_arb_ok) begin
                r_grant_idx <= w_winner;
                r_hgrant    <= w_next_hgrant;
                if (w_found) r_rr_ptr <= w_winner;
            end
            if (bus.HREADY) begin
                r_hmaster   <= r_grant_idx;
                r_hmastlock <= w_owner_lock;
                r_dmaster   <= r_hmaster;
            end
        end
    end

    assign bus.HGRANT    = r_hgrant;
    assign bus.HMASTER   = r_hmaster;
    assign bus.HMASTLOCK = r_hmastlock;

endmodule
